// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus layout,
// stall masks, controller state encodings and the default exception vector.
package pipeline_ctrl_pkg;

  localparam int STALL_BUS_WIDTH = 6;
  typedef logic [STALL_BUS_WIDTH-1:0] stall_bus_t;

  // Bit k freezes stage k; bit 5 (WB) is never set so a bubble always drains.
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  function automatic logic stall_active(input stall_bus_t s);
    return |s;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Reusable for any single-bit performance event.
module pipeline_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: async reset, sync clear, increment until all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges hazard stalls, the MEM-stage RAM
// handshake (with timeout) and exceptions into stall, flush and redirect.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [ADDR_W-1:0] EXC_VECTOR     = ADDR_W'(EXC_VECTOR_DEFAULT),
  parameter int                CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_req,
  input  logic              ram_resp_valid,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_target,
  input  logic              perf_clr,
  output logic              ram_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              bus_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e       state_r, state_nxt_s;
  logic [TO_W-1:0]   cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] target_r, target_nxt_s;

  stall_bus_t        stall_s;
  logic              ram_req_s;
  logic              flush_s;
  logic              redirect_valid_s;
  logic [ADDR_W-1:0] redirect_pc_s;
  logic              bus_err_s;

  // State, timeout counter and redirect target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      target_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      target_r <= target_nxt_s;
    end
  end

  // Next-state and output decode; outputs are forced low while rst is held.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    target_nxt_s     = target_r;
    stall_s          = STALL_NONE;
    ram_req_s        = 1'b0;
    flush_s          = 1'b0;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = '0;
    bus_err_s        = 1'b0;
    if (!rst) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (exc_valid) begin
            // Faulting access is never issued; MEM bubble keeps it out of WB.
            stall_s      = STALL_MEM;
            target_nxt_s = exc_target;
            state_nxt_s  = ST_FLUSH;
          end else if (mem_req && ram_resp_valid) begin
            ram_req_s = 1'b1;
          end else if (mem_req) begin
            ram_req_s   = 1'b1;
            stall_s     = STALL_MEM;
            cnt_nxt_s   = '0;
            state_nxt_s = ST_WAIT;
          end else if (ex_stall_req) begin
            stall_s = STALL_EX;
          end else if (id_stall_req) begin
            stall_s = STALL_ID;
          end else begin
            stall_s = STALL_NONE;
          end
        end
        ST_WAIT: begin
          if (ram_resp_valid) begin
            state_nxt_s = ST_IDLE;
          end else if (cnt_r == TO_LAST) begin
            bus_err_s    = 1'b1;
            stall_s      = STALL_MEM;
            target_nxt_s = EXC_VECTOR;
            state_nxt_s  = ST_FLUSH;
          end else begin
            stall_s   = STALL_MEM;
            cnt_nxt_s = cnt_r + TO_W'(1);
          end
        end
        ST_FLUSH: begin
          flush_s          = 1'b1;
          redirect_valid_s = 1'b1;
          redirect_pc_s    = target_r;
          state_nxt_s      = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  pipeline_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (stall_active(stall_s)),
    .count (stall_cycles)
  );

  assign stall          = stall_s;
  assign ram_req        = ram_req_s;
  assign flush          = flush_s;
  assign redirect_valid = redirect_valid_s;
  assign redirect_pc    = redirect_pc_s;
  assign bus_err        = bus_err_s;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the five-stage core. It turns stage stall requests, the MEM-stage RAM handshake and MEM-stage exceptions into the per-stage stall vector consumed by every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB). It also produces the flush and PC-redirect pulses. It holds a RAM wait FSM with a timeout and a saturating stall-cycle performance counter.

Parameters:
ADDR_W, 32, PC/target width
TIMEOUT_CYCLES, 16, max WAIT cycles before bus error (>=2)
EXC_VECTOR, 32'hBFC0_0380, redirect target on RAM timeout
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
id_stall_req  in  1  ID load-use hazard
ex_stall_req  in  1  EX multi-cycle op busy (div)
mem_req  in  1  MEM stage holds a load/store
ram_resp_valid  in  1  RAM data/ack for the outstanding access
exc_valid  in  1  MEM-stage instruction raises an exception
exc_target  in  ADDR_W  handler PC for exc_valid
perf_clr  in  1  synchronous clear of stall_cycles
ram_req  out  1  issue RAM access this cycle
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
flush  out  1  clear IF/ID, ID/EX, EX/MEM, MEM/WB contents
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  ADDR_W  redirect target
bus_err  out  1  one-cycle pulse on RAM timeout
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- The register between stage k and k+1 uses stall[k] as stall_current_stage and stall[k+1] as stall_next_stage. stall[5] is constantly 0.
- FSM states: IDLE, WAIT, FLUSH. Registered state, redirect target and timeout counter.
- Reset (rst low, async): state=IDLE; timeout cnt=0; target=0; stall_cycles=0. All outputs 0.
- IDLE, priority (first match wins):
  1. exc_valid: stall=6'b011111, ram_req=0 (faulting access suppressed). Latch exc_target. Next state FLUSH.
  2. mem_req & ram_resp_valid: ram_req=1, stall=0, stay IDLE (zero-wait access).
  3. mem_req & !ram_resp_valid: ram_req=1, stall=6'b011111, cnt=0. Next state WAIT.
  4. ex_stall_req: stall=6'b001111.
  5. id_stall_req: stall=6'b000111.
  6. Otherwise stall=0.
- WAIT:
  - ram_req=0; exc_valid, id_stall_req and ex_stall_req are ignored.
  - ram_resp_valid: stall=0 (MEM/WB captures data at this edge). Next state IDLE.
  - Else if cnt==TIMEOUT_CYCLES-1: bus_err=1, stall=6'b011111. Latch EXC_VECTOR. Next state FLUSH.
  - Else: stall=6'b011111, cnt+1.
- FLUSH (exactly 1 cycle):
  - flush=1, redirect_valid=1, redirect_pc=latched target, stall=0, ram_req=0.
  - All request inputs, including exc_valid and a late ram_resp_valid, are ignored.
  - Next state IDLE.
- ram_resp_valid outside WAIT and outside IDLE case 2 is ignored.
- redirect_pc reads 0 whenever redirect_valid=0.
- stall_cycles: +1 on each cycle with stall!=0; saturates at all-ones. perf_clr has priority over the increment (result 0).
- Exception latency: exc_valid at cycle T gives flush/redirect at T+1. The faulting instruction never reaches WB, because a bubble is inserted by stall[4]=1 with stall[5]=0.
- RAM read latency: N wait cycles cost exactly N stall cycles.
- rst asserted mid-WAIT or mid-FLUSH aborts immediately to IDLE with no redirect.

Decomposition:
- Shared bus.v: STALL_BUS (5:0), STALL_BUS_WIDTH, stall masks (STALL_NONE, STALL_ID, STALL_EX, STALL_MEM), FSM state encodings, EXC_VECTOR default.
- Sub-module: sat_counter (CNT_W, clr, inc), a saturating performance counter reusable for other perf events.

Test Plan:
- Reset mid-WAIT: drive mem_req=1, ram_resp_valid=0 for 3 cycles, then pulse rst low -> stall=0 and state IDLE asynchronously; after release, stall_cycles=0.
- Zero-wait load: mem_req=1 with ram_resp_valid=1 in the same cycle -> ram_req=1, stall=0, stall_cycles unchanged.
- 3-wait load: mem_req=1, resp arrives on the 4th cycle -> ram_req high for the first cycle only; stall=011111 for 3 cycles, then 000000; stall_cycles=3.
- Priority: id_stall_req=1, ex_stall_req=1 -> stall=001111. Add mem_req=1 with no resp -> 011111. Add exc_valid=1 with exc_target=32'h8000_0180 -> ram_req=0, stall=011111; next cycle flush=1, redirect_pc=32'h8000_0180.
- Timeout with TIMEOUT_CYCLES=4: mem_req=1, no resp -> bus_err on the 4th cycle in WAIT, then flush=1 and redirect_pc=32'hBFC0_0380 one cycle later. A late resp arriving in FLUSH is ignored.
- Counter saturation: preload via long stall with CNT_W=4 -> stall_cycles holds 4'hF. perf_clr together with an active stall -> 0.
